mem_port_arbiter: RTL and testbench

Shares one single-ported 64-bit doubleword memory among the core's three memory clients: instruction fetch (F), doubleword load (L) and doubleword store (S). Each client issues one request at a time with a level req/done handshake. The arbiter serializes the requests onto the memory port with fixed priority S > L > F plus fetch anti-starvation, and returns read data to the winning client. It replaces the separate fetch and data read ports so the core's multi-cycle F/D/X/WB sequencer can run against a single-port memory.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port doubleword memory arbiter for fetch (F), load (L) and store (S) clients.
// One transaction in flight; fixed priority S > L > F with a fetch anti-starvation override.
module mem_port_arbiter #(
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fReq,
    input  logic [60:0] fAddr,
    output logic        fDone,
    output logic [63:0] fData,
    input  logic        lReq,
    input  logic [60:0] lAddr,
    output logic        lDone,
    output logic [63:0] lData,
    input  logic        sReq,
    input  logic [60:0] sAddr,
    input  logic [63:0] sData,
    output logic        sDone,
    output logic        memEn,
    output logic        memWe,
    output logic [60:0] memAddr,
    output logic [63:0] memWData,
    input  logic [63:0] memRData,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    localparam logic [1:0] G_NONE     = 2'd0;
    localparam logic [1:0] G_F        = 2'd1;
    localparam logic [1:0] G_L        = 2'd2;
    localparam logic [1:0] G_S        = 2'd3;
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [2:0] WAIT_INIT  = 3'(READ_LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]  starve_cnt_q, starve_cnt_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [60:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic        f_done_q, f_done_d;
    logic        l_done_q, l_done_d;
    logic        s_done_q, s_done_d;
    logic [63:0] f_data_q, f_data_d;
    logic [63:0] l_data_q, l_data_d;
    logic        f_wins;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        f_done_d     = 1'b0;
        l_done_d     = 1'b0;
        s_done_d     = 1'b0;
        f_data_d     = f_data_q;
        l_data_d     = l_data_q;
        f_wins       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A starved fetch overrides even a pending store.
                f_wins = fReq && ((starve_cnt_q == STARVE_LIM) || (!sReq && !lReq));
                if (!fReq || f_wins) begin
                    starve_cnt_d = '0;
                end else if (starve_cnt_q != STARVE_LIM) begin
                    starve_cnt_d = starve_cnt_q + 3'd1;
                end
                if (fReq || lReq || sReq) begin
                    state_d  = ST_ISSUE;
                    mem_en_d = 1'b1;
                    if (f_wins) begin
                        grant_d    = G_F;
                        mem_addr_d = fAddr;
                    end else if (sReq) begin
                        grant_d     = G_S;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = sAddr;
                        mem_wdata_d = sData;
                    end else begin
                        grant_d    = G_L;
                        mem_addr_d = lAddr;
                    end
                end
            end
            ST_ISSUE: begin
                if (grant_q == G_S) begin
                    s_done_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    wait_cnt_d = WAIT_INIT;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (grant_q == G_F) begin
                        f_done_d = 1'b1;
                        f_data_d = memRData;
                    end else begin
                        l_done_d = 1'b1;
                        l_data_d = memRData;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                grant_d = G_NONE;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= G_NONE;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            f_done_q     <= 1'b0;
            l_done_q     <= 1'b0;
            s_done_q     <= 1'b0;
            f_data_q     <= '0;
            l_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            f_done_q     <= f_done_d;
            l_done_q     <= l_done_d;
            s_done_q     <= s_done_d;
            f_data_q     <= f_data_d;
            l_data_q     <= l_data_d;
        end
    end

    assign fDone    = f_done_q;
    assign lDone    = l_done_q;
    assign sDone    = s_done_q;
    assign fData    = f_data_q;
    assign lData    = l_data_q;
    assign memEn    = mem_en_q;
    assign memWe    = mem_we_q;
    assign memAddr  = mem_addr_q;
    assign memWData = mem_wdata_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-timeline reference model predicts
// memory strobes, grants and completions; a monitor compares them against the DUT.
module tb_mem_port_arbiter;

    localparam int RL = 1;
    localparam int SM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fReq, lReq, sReq;
    logic [60:0] fAddr, lAddr, sAddr;
    logic [63:0] sData;
    logic        fDone, lDone, sDone;
    logic [63:0] fData, lData;
    logic        memEn, memWe;
    logic [60:0] memAddr;
    logic [63:0] memWData, memRData;
    logic [1:0]  grant;

    // second instance: longer read latency, most aggressive starvation limit
    logic        f3Req, l3Req;
    logic [60:0] f3Addr, l3Addr;
    logic        f3Done, l3Done, s3Done;
    logic [63:0] f3Data, l3Data;
    logic        mem3En, mem3We;
    logic [60:0] mem3Addr;
    logic [63:0] mem3WData, mem3RData;
    logic [1:0]  grant3;

    always #5 clk = ~clk;

    mem_port_arbiter #(.READ_LAT(RL), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .fReq(fReq), .fAddr(fAddr), .fDone(fDone), .fData(fData),
        .lReq(lReq), .lAddr(lAddr), .lDone(lDone), .lData(lData),
        .sReq(sReq), .sAddr(sAddr), .sData(sData), .sDone(sDone),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .grant(grant)
    );

    mem_port_arbiter #(.READ_LAT(3), .STARVE_MAX(1)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .fReq(f3Req), .fAddr(f3Addr), .fDone(f3Done), .fData(f3Data),
        .lReq(l3Req), .lAddr(l3Addr), .lDone(l3Done), .lData(l3Data),
        .sReq(1'b0), .sAddr(61'd0), .sData(64'd0), .sDone(s3Done),
        .memEn(mem3En), .memWe(mem3We), .memAddr(mem3Addr), .memWData(mem3WData),
        .memRData(mem3RData), .grant(grant3)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] init_val(input int i);
        if (i == 5) return 64'h1122_3344_5566_7788;
        return 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);
    endfunction

    function automatic logic [63:0] rd3(input logic [60:0] a);
        return {3'b101, a} ^ 64'h0F0F_0F0F_0F0F_0F0F;
    endfunction

    function automatic logic [60:0] rnd_addr();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[60:0];
    endfunction

    // Memory device for the main DUT: 16 doublewords aliased on memAddr[3:0].
    logic [63:0] phys [16];
    bit          phys_wr [16];
    logic [63:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (memEn && memWe) begin
            phys[memAddr[3:0]]    <= memWData;
            phys_wr[memAddr[3:0]] <= 1'b1;
        end
        rd_pipe[0] <= (memEn && !memWe)
                      ? (phys_wr[memAddr[3:0]] ? phys[memAddr[3:0]] : init_val(int'(memAddr[3:0])))
                      : {$urandom, $urandom};
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign memRData = rd_pipe[RL-1];

    logic [63:0] pipe3 [3];
    always @(posedge clk) begin
        pipe3[0] <= mem3En ? rd3(mem3Addr) : {$urandom, $urandom};
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem3RData = pipe3[2];

    typedef struct { int cyc; int who; logic [63:0] data; } resp_t;
    typedef struct { int cyc; logic we; logic [60:0] addr; logic [63:0] wdata; } memop_t;
    resp_t  resp_q[$];
    memop_t mem_q[$];
    int     exp_grant[int];

    // Reference model: at each cycle where the port is free, pick a winner from the
    // sampled requests and schedule that whole transaction on the timeline.
    initial begin : model
        logic [63:0] ref_mem [16];
        int          starve;
        int          next_arb;
        int          w;
        int          dn;
        logic [60:0] a;
        starve = 0;
        next_arb = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                resp_q.delete();
                mem_q.delete();
                exp_grant.delete();
                starve = 0;
                next_arb = 0;
            end else if (cyc >= next_arb) begin
                if (!(fReq || lReq || sReq)) begin
                    starve = 0;
                end else begin
                    if (fReq && (starve == SM || (!sReq && !lReq))) w = 1;
                    else if (sReq) w = 3;
                    else w = 2;
                    if (!fReq || w == 1) starve = 0;
                    else if (starve < SM) starve++;
                    a = (w == 1) ? fAddr : (w == 2) ? lAddr : sAddr;
                    if (w == 3) begin
                        ref_mem[a[3:0]] = sData;
                        mem_q.push_back('{cyc + 1, 1'b1, a, sData});
                        dn = cyc + 2;
                        resp_q.push_back('{dn, 3, 64'h0});
                    end else begin
                        mem_q.push_back('{cyc + 1, 1'b0, a, 64'h0});
                        dn = cyc + 2 + RL;
                        resp_q.push_back('{dn, w, ref_mem[a[3:0]]});
                    end
                    next_arb = dn + 1;
                    for (int k = cyc + 1; k <= dn; k++) exp_grant[k] = w;
                end
            end
            cyc++;
        end
    end

    // Monitor: sample on the falling edge, pop expectations as the DUT presents events.
    initial begin : monitor
        resp_t       r;
        memop_t      m;
        logic [2:0]  dn;
        logic [63:0] exp_fdata;
        logic [63:0] exp_ldata;
        exp_fdata = '0;
        exp_ldata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_fdata = '0;
                exp_ldata = '0;
            end
            dn = {sDone, lDone, fDone};
            if (dn != 3'b000) begin
                if (resp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=%b, expected none (cycle %0d)", dn, cyc);
                end else begin
                    r = resp_q.pop_front();
                    check("done_client", 64'(dn), 64'(3'b001 << (r.who - 1)));
                    check("done_cycle", 64'(cyc), 64'(r.cyc));
                    if (r.who == 1) exp_fdata = r.data;
                    if (r.who == 2) exp_ldata = r.data;
                end
            end else if (resp_q.size() != 0 && resp_q[0].cyc < cyc) begin
                r = resp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL done_timeout: got no done, expected client %0d at cycle %0d", r.who, r.cyc);
            end
            check("fData", fData, exp_fdata);
            check("lData", lData, exp_ldata);
            if (memEn) begin
                if (mem_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_memEn: got memEn=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_cycle", 64'(cyc), 64'(m.cyc));
                    check("mem_we", 64'(memWe), 64'(m.we));
                    check("mem_addr", 64'(memAddr), 64'(m.addr));
                    if (m.we) check("mem_wdata", memWData, m.wdata);
                end
            end else begin
                check("mem_idle_quiet", 64'(memWe || (memWData != 0)), 64'd0);
                if (mem_q.size() != 0 && mem_q[0].cyc < cyc) begin
                    m = mem_q.pop_front();
                    vectors++;
                    miscompares++;
                    $display("FAIL memEn_timeout: got none, expected memEn at cycle %0d", m.cyc);
                end
            end
            check("grant", 64'(grant), 64'(exp_grant.exists(cyc) ? exp_grant[cyc] : 0));
        end
    end

    task automatic settle(input int maxc);
        int n;
        n = 0;
        while ((fReq || lReq || sReq || resp_q.size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
            if (fDone) fReq = 1'b0;
            if (lDone) lReq = 1'b0;
            if (sDone) sReq = 1'b0;
        end
        check("settle_drained", 64'(fReq || lReq || sReq || resp_q.size() != 0), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic drive_random(input int ncyc);
        repeat (ncyc) begin
            @(negedge clk);
            if (fDone) begin
                if ($urandom_range(0, 1) == 1) fAddr = rnd_addr();
                else fReq = 1'b0;
            end else if (!fReq && $urandom_range(0, 3) == 0) begin
                fReq = 1'b1;
                fAddr = rnd_addr();
            end
            if (lDone) begin
                if ($urandom_range(0, 1) == 1) lAddr = rnd_addr();
                else lReq = 1'b0;
            end else if (!lReq && $urandom_range(0, 3) == 0) begin
                lReq = 1'b1;
                lAddr = rnd_addr();
            end
            if (sDone) begin
                sReq = 1'b0;
            end else if (!sReq && $urandom_range(0, 5) == 0) begin
                sReq = 1'b1;
                sAddr = rnd_addr();
                sData = {$urandom, $urandom};
            end
        end
    endtask

    initial begin : stim
        int nl;
        bit got;
        int n;
        logic [1:0] g;
        fReq = 0; lReq = 0; sReq = 0;
        fAddr = '0; lAddr = '0; sAddr = '0; sData = '0;
        f3Req = 0; l3Req = 0; f3Addr = '0; l3Addr = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_ctl", 64'({fDone, lDone, sDone, memEn, memWe, grant}), 64'd0);
        check("rst_mem", 64'((memAddr != 0) || (memWData != 0)), 64'd0);
        check("rst_data", fData | lData, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // store then load to the same doubleword
        sReq = 1; sAddr = 61'd7; sData = 64'hDEAD_BEEF_CAFE_F00D;
        settle(20);
        @(negedge clk);
        lReq = 1; lAddr = 61'd7;
        settle(20);
        check("load_after_store", lData, 64'hDEAD_BEEF_CAFE_F00D);
        check("fData_untouched", fData, 64'd0);

        @(negedge clk);
        fReq = 1; fAddr = 61'd5;
        settle(20);
        check("fetch_mem5", fData, 64'h1122_3344_5566_7788);

        // all three at once
        @(negedge clk);
        fReq = 1; fAddr = 61'd1;
        lReq = 1; lAddr = 61'd2;
        sReq = 1; sAddr = 61'd3; sData = 64'h0BAD_F00D_1234_5678;
        settle(40);

        // load re-requests immediately, fetch held high
        @(negedge clk);
        fReq = 1; fAddr = 61'd4;
        lReq = 1; lAddr = 61'd6;
        nl = 0; got = 0; n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (lDone) nl++;
            if (fDone) begin
                got = 1;
                fReq = 0;
                lReq = 0;
            end
        end
        check("starve_loads_before_fetch", 64'(nl), 64'd3);
        check("starve_fetch_done", 64'(got), 64'd1);
        settle(20);

        // reset while the fetch is in WAIT
        @(negedge clk);
        fReq = 1; fAddr = 61'd9;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        fReq = 0;
        #1;
        check("midrst_ctl", 64'({fDone, lDone, sDone, memEn, memWe, grant}), 64'd0);
        check("midrst_mem", 64'((memAddr != 0) || (memWData != 0)), 64'd0);
        check("midrst_data", fData | lData, 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_fDone", 64'(fDone), 64'd0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("postrst_no_fDone", 64'(fDone), 64'd0);
        end
        fReq = 1; fAddr = 61'd9;
        settle(20);
        check("postrst_fetch", fData, init_val(9));

        drive_random(2500);
        settle(200);

        // READ_LAT=3, STARVE_MAX=1 instance, cycle-exact
        @(negedge clk);
        f3Addr = 61'h0AB; l3Addr = 61'h1CD;
        f3Req = 1; l3Req = 1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            check("r3_memEn", 64'(mem3En), 64'(c == 1 || c == 7 || c == 13));
            if (c == 1 || c == 13) check("r3_addr_load", 64'(mem3Addr), 64'(l3Addr));
            if (c == 7) check("r3_addr_fetch", 64'(mem3Addr), 64'(f3Addr));
            check("r3_lDone", 64'(l3Done), 64'(c == 5 || c == 17));
            check("r3_fDone", 64'(f3Done), 64'(c == 11));
            if (c == 5 || c == 17) check("r3_lData", l3Data, rd3(l3Addr));
            if (c == 11) check("r3_fData", f3Data, rd3(f3Addr));
            check("r3_no_write", 64'(mem3We || s3Done || (mem3WData != 0)), 64'd0);
            g = ((c >= 1 && c <= 5) || (c >= 13 && c <= 17)) ? 2'd2 : (c >= 7 && c <= 11) ? 2'd1 : 2'd0;
            check("r3_grant", 64'(grant3), 64'(g));
            if (c == 11) f3Req = 0;
            if (c == 17) l3Req = 0;
        end

        check("queues_drained", 64'(resp_q.size() + mem_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
